pll_freq_switch: RTL and testbench
==================================

Name: pll_freq_switch

Overview:
- Standalone PLL reconfiguration sequencer on the CLK_50M management domain.
- Converts the OSD frequency select (48.000 MHz original / 50.526 MHz 60 Hz overclock) into write transactions on the pll_cfg management port.
- Holds the game core in reset while the clock is unstable, signals a video mode change to hps_io, and handles lock timeout and retry.
- Sits between the OSD status bits and pll_cfg, feeding the core reset and new_vmode.

Parameters:
- C_SLOW, 32'h00000A0A: C-counter word for C=20 (48.000 MHz).
- C_FAST, 32'h00020A09: C-counter word for C=19 (50.526 MHz).
- C_ADDR, 6'h05: management address of the C-counter register.
- START_ADDR, 6'h02: management address of the reconfig start register.
- SETTLE_CYCLES, 1024: cycles freq_sel must be stable before acting.
- LOCK_BLANK, 16: cycles after start during which pll_locked is ignored.
- LOCK_TIMEOUT, 1048576: maximum cycles to wait for lock.
- RETRY_MAX, 3: reprogram attempts before FAULT.

Ports:
- CLK_50M  in  1  management clock.
- RESET  in  1  asynchronous, active-high reset.
- freq_sel  in  1  0 = 48 MHz, 1 = 50.526 MHz; asynchronous, 2-FF synchronised internally.
- pll_locked  in  1  PLL lock; asynchronous, 2-FF synchronised internally.
- mgmt_waitrequest  in  1  pll_cfg stall.
- mgmt_write  out  1  write strobe.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  register data.
- core_hold  out  1  OR'd into the core reset while the clock is unstable.
- new_vmode  out  1  toggles once per successful lock.
- busy  out  1  sequence in progress.
- error  out  1  lock failure after all retries.
- cur_freq  out  1  frequency currently programmed and locked.

Behaviour:
- Reset values (asynchronous, on RESET high):
  - state = INIT; init_pending = 1.
  - mgmt_write = 0; mgmt_address = 0; mgmt_writedata = 0.
  - core_hold = 1; busy = 1; new_vmode = 0; error = 0; cur_freq = 0; retry count = 0.
- Reset mid-transaction drops mgmt_write immediately. After release, a full reprogram runs with no settle wait.
- Write handshake:
  - Drive mgmt_write = 1 with stable address and data.
  - The transaction completes in the cycle where mgmt_write = 1 and mgmt_waitrequest = 0.
  - Deassert mgmt_write the following cycle.
  - Address and data must not change while waitrequest = 1.
- States:
  - INIT: latch target = sync freq_sel, go to WR_C.
  - IDLE:
    - busy = 0, core_hold = 0.
    - If sync freq_sel != cur_freq, go to SETTLE and clear the counter.
  - SETTLE:
    - Count up while sync freq_sel stays at the new value. Any toggle restarts the count.
    - If it returns to cur_freq, go back to IDLE.
    - At SETTLE_CYCLES: latch target, set core_hold = 1 and busy = 1, go to WR_C.
  - WR_C: write (C_ADDR, target ? C_FAST : C_SLOW), then go to WR_GAP.
  - WR_GAP: one cycle with mgmt_write = 0, then go to WR_START.
  - WR_START: write (START_ADDR, 32'h1), then go to WAIT_LOCK and clear the timer.
  - WAIT_LOCK:
    - Ignore pll_locked for LOCK_BLANK cycles.
    - After the blank window, sync pll_locked = 1 goes to DONE.
    - Timer reaching LOCK_TIMEOUT: increment retry. If retry < RETRY_MAX go to WR_C, otherwise go to FAULT.
  - DONE (1 cycle):
    - cur_freq = target; toggle new_vmode; clear error and retry; release core_hold.
    - Go to IDLE. IDLE then re-evaluates immediately, so a freq_sel change made during programming is serviced next.
  - FAULT:
    - error = 1, core_hold = 0, busy = 0.
    - A new sync freq_sel edge goes to SETTLE. error stays set until a DONE.
- Latency: freq_sel edge to first mgmt_write = 2 (sync) + SETTLE_CYCLES + 1 cycles, assuming no stall.
- Counter widths: settle counter is clog2(SETTLE_CYCLES + 1) bits; timer is clog2(LOCK_TIMEOUT + 1) bits. Both saturate, never wrap.
- freq_sel changes during WR_C, WR_START or WAIT_LOCK do not abort the sequence.

Decomposition:
- Package pll_switch_pkg:
  - state enum.
  - C_SLOW / C_FAST / C_ADDR / START_ADDR defaults.
- Sub-module mgmt_writer: single-transaction Avalon-MM write engine with req/done handshake.
  - Used twice per sequence by the FSM.
  - Keeps the waitrequest rules in one place.

Test Plan:
- Reset release with freq_sel = 0 and waitrequest = 0 -> writes (05, 00000A0A) then (02, 00000001). pll_locked asserted 100 cycles later -> after sync, DONE: new_vmode 0 -> 1, core_hold 1 -> 0, cur_freq = 0.
- freq_sel 0 -> 1, held -> first write 2 + 1024 + 1 cycles after the edge, data 00020A09. After lock, cur_freq = 1.
- freq_sel glitch 0 -> 1 -> 0 within 500 cycles -> no mgmt_write, core_hold stays 0, new_vmode unchanged.
- mgmt_waitrequest held high 7 cycles during the C write -> mgmt_write, address and data stable all 8 cycles. Exactly one completed write.
- pll_locked never asserts (LOCK_TIMEOUT reduced to 256) -> 3 full write pairs, then error = 1, busy = 0, core_hold = 0. A subsequent good lock clears error.
- RESET pulsed during WAIT_LOCK -> mgmt_write 0 and core_hold 1 asynchronously. After release, a complete reprogram runs without SETTLE.

Source files
------------

// File: rtl/pll_switch_pkg.sv
// Shared types and register constants for the PLL frequency switch sequencer.
// The sequencer top and its management write engine both import this package.
package pll_switch_pkg;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    SETTLE,
    WR_C,
    WR_GAP,
    WR_START,
    WAIT_LOCK,
    DONE,
    FAULT
  } pll_state_t;

  // C-counter words: C=20 gives 48.000 MHz, C=19 gives the 60 Hz overclock
  localparam logic [31:0] C_SLOW     = 32'h0000_0A0A;
  localparam logic [31:0] C_FAST     = 32'h0002_0A09;
  localparam logic [5:0]  C_ADDR     = 6'h05;
  localparam logic [5:0]  START_ADDR = 6'h02;
  localparam logic [31:0] START_DATA = 32'h0000_0001;

  localparam int SETTLE_CYCLES_DEF = 1024;
  localparam int LOCK_BLANK_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF  = 1048576;
  localparam int RETRY_MAX_DEF     = 3;

endpackage

// File: rtl/pll_freq_switch_mgmt_writer.sv
// Single-transaction Avalon-MM write engine: one req launches one write, done
// marks the accepting cycle. Address and data are latched so a stall cannot move them.
module mgmt_writer
  import pll_switch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [5:0]  addr,
  input  logic [31:0] data,
  input  logic        waitrequest,
  output logic        done,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata
);

  assign done = mgmt_write & ~waitrequest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else if (!mgmt_write) begin
      if (req) begin
        mgmt_write     <= 1'b1;
        mgmt_address   <= addr;
        mgmt_writedata <= data;
      end
    end else if (!waitrequest) begin
      mgmt_write <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_freq_switch.sv
// PLL reconfiguration sequencer: debounces the OSD frequency select, reprograms the
// C counter through pll_cfg, waits for lock with retry, and gates the core reset.
module pll_freq_switch
  import pll_switch_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int LOCK_BLANK    = LOCK_BLANK_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int RETRY_MAX     = RETRY_MAX_DEF
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        freq_sel,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        core_hold,
  output logic        new_vmode,
  output logic        busy,
  output logic        error,
  output logic        cur_freq
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);

  pll_state_t    state, state_n;
  logic [SW-1:0] settle_cnt, settle_cnt_n, settle_inc;
  logic [TW-1:0] timer, timer_n, timer_inc;
  logic [RW-1:0] retry, retry_n, retry_inc;
  logic          target, target_n;
  logic          core_hold_n, busy_n, error_n, cur_freq_n, new_vmode_n;
  logic          freq_meta, freq_s, freq_d;
  logic          lock_meta, lock_s;
  logic          wr_req, wr_done;
  logic [5:0]    wr_addr;
  logic [31:0]   wr_data;

  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      freq_meta <= 1'b0;
      freq_s    <= 1'b0;
      freq_d    <= 1'b0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      freq_meta <= freq_sel;
      freq_s    <= freq_meta;
      freq_d    <= freq_s;
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      state      <= INIT;
      settle_cnt <= '0;
      timer      <= '0;
      retry      <= '0;
      target     <= 1'b0;
      core_hold  <= 1'b1;
      busy       <= 1'b1;
      error      <= 1'b0;
      cur_freq   <= 1'b0;
      new_vmode  <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      timer      <= timer_n;
      retry      <= retry_n;
      target     <= target_n;
      core_hold  <= core_hold_n;
      busy       <= busy_n;
      error      <= error_n;
      cur_freq   <= cur_freq_n;
      new_vmode  <= new_vmode_n;
    end
  end

  // Both counters saturate so a stuck input can never wrap them back into range
  assign settle_inc = (settle_cnt == SW'(SETTLE_CYCLES)) ? settle_cnt : settle_cnt + SW'(1);
  assign timer_inc  = (timer == TW'(LOCK_TIMEOUT)) ? timer : timer + TW'(1);
  assign retry_inc  = (retry == RW'(RETRY_MAX)) ? retry : retry + RW'(1);

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    timer_n      = timer;
    retry_n      = retry;
    target_n     = target;
    core_hold_n  = core_hold;
    busy_n       = busy;
    error_n      = error;
    cur_freq_n   = cur_freq;
    new_vmode_n  = new_vmode;
    wr_req       = 1'b0;
    wr_addr      = C_ADDR;
    wr_data      = target ? C_FAST : C_SLOW;

    case (state)
      INIT: begin
        target_n    = freq_s;
        retry_n     = '0;
        core_hold_n = 1'b1;
        busy_n      = 1'b1;
        state_n     = WR_C;
      end
      IDLE: begin
        core_hold_n = 1'b0;
        busy_n      = 1'b0;
        if (freq_s != cur_freq) begin
          settle_cnt_n = '0;
          state_n      = SETTLE;
        end
      end
      SETTLE: begin
        if (freq_s == cur_freq) begin
          state_n = IDLE;
        end else if (freq_s != freq_d) begin
          settle_cnt_n = '0;
        end else begin
          settle_cnt_n = settle_inc;
          if (settle_inc == SW'(SETTLE_CYCLES)) begin
            target_n    = freq_s;
            retry_n     = '0;
            core_hold_n = 1'b1;
            busy_n      = 1'b1;
            state_n     = WR_C;
          end
        end
      end
      WR_C: begin
        wr_req = 1'b1;
        if (wr_done) state_n = WR_GAP;
      end
      WR_GAP: begin
        state_n = WR_START;
      end
      WR_START: begin
        wr_req  = 1'b1;
        wr_addr = START_ADDR;
        wr_data = START_DATA;
        if (wr_done) begin
          timer_n = '0;
          state_n = WAIT_LOCK;
        end
      end
      // Lock is ignored during the blank window: the old lock may still be visible
      WAIT_LOCK: begin
        timer_n = timer_inc;
        if (lock_s && (timer >= TW'(LOCK_BLANK))) begin
          state_n = DONE;
        end else if (timer_inc == TW'(LOCK_TIMEOUT)) begin
          retry_n = retry_inc;
          if (retry_inc < RW'(RETRY_MAX)) begin
            state_n = WR_C;
          end else begin
            error_n     = 1'b1;
            core_hold_n = 1'b0;
            busy_n      = 1'b0;
            state_n     = FAULT;
          end
        end
      end
      DONE: begin
        cur_freq_n  = target;
        new_vmode_n = ~new_vmode;
        error_n     = 1'b0;
        retry_n     = '0;
        core_hold_n = 1'b0;
        busy_n      = 1'b0;
        state_n     = IDLE;
      end
      FAULT: begin
        error_n     = 1'b1;
        core_hold_n = 1'b0;
        busy_n      = 1'b0;
        if (freq_s != freq_d) begin
          settle_cnt_n = '0;
          state_n      = SETTLE;
        end
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  mgmt_writer u_writer (
    .clk            (CLK_50M),
    .rst            (RESET),
    .req            (wr_req),
    .addr           (wr_addr),
    .data           (wr_data),
    .waitrequest    (mgmt_waitrequest),
    .done           (wr_done),
    .mgmt_write     (mgmt_write),
    .mgmt_address   (mgmt_address),
    .mgmt_writedata (mgmt_writedata)
  );

endmodule

// File: tb/tb_pll_freq_switch.sv
// Directed bench for pll_freq_switch with a shortened lock timeout; every
// completed management write is logged and compared against hand-computed values.
module tb_pll_freq_switch;

  logic        CLK_50M = 1'b0;
  logic        RESET = 1'b1;
  logic        freq_sel = 1'b0;
  logic        pll_locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        core_hold, new_vmode, busy, error, cur_freq;

  int n_checks = 0;
  int n_fail = 0;
  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  pll_freq_switch #(
    .SETTLE_CYCLES (1024),
    .LOCK_BLANK    (16),
    .LOCK_TIMEOUT  (256),
    .RETRY_MAX     (3)
  ) dut (
    .CLK_50M          (CLK_50M),
    .RESET            (RESET),
    .freq_sel         (freq_sel),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .core_hold        (core_hold),
    .new_vmode        (new_vmode),
    .busy             (busy),
    .error            (error),
    .cur_freq         (cur_freq)
  );

  always #10 CLK_50M = ~CLK_50M;

  // A write completes on the rising edge that follows a negedge showing write && !waitrequest
  always @(negedge CLK_50M) begin
    if (!RESET && mgmt_write && !mgmt_waitrequest) begin
      wr_addr_q.push_back(mgmt_address);
      wr_data_q.push_back(mgmt_writedata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic l, input logic w);
    freq_sel         = f;
    pll_locked       = l;
    mgmt_waitrequest = w;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK_50M);
      #1;
    end
  endtask

  function automatic logic [5:0] log_addr(input int i);
    return (wr_addr_q.size() > i) ? wr_addr_q[i] : 6'h3F;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (wr_data_q.size() > i) ? wr_data_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wr_addr_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    checkOutput(tag, 32'(wr_addr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_vmode(input string tag, input logic v, input int budget);
    int k = 0;
    while (new_vmode !== v && k < budget) begin
      step(1);
      k++;
    end
    checkOutput(tag, 32'(new_vmode), 32'(v));
  endtask

  task automatic wait_error(input string tag, input int budget);
    int k = 0;
    while (error !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    checkOutput(tag, 32'(error), 32'd1);
  endtask

  task automatic wait_write_high(input int budget, output int lat);
    lat = 0;
    while (mgmt_write !== 1'b1 && lat < budget) begin
      step(1);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int c_writes;
    logic [5:0]  a_hold;
    logic [31:0] d_hold;
    logic        stable;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0);
    RESET = 1'b1;
    step(3);
    checkOutput("rst_write", 32'(mgmt_write), 32'd0);
    checkOutput("rst_addr", 32'(mgmt_address), 32'd0);
    checkOutput("rst_data", mgmt_writedata, 32'd0);
    checkOutput("rst_hold", 32'(core_hold), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_vmode", 32'(new_vmode), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_freq", 32'(cur_freq), 32'd0);

    // Power-up programming at 48 MHz, no settle wait
    RESET = 1'b0;
    wait_writes("t1_writes", 2, 50);
    checkOutput("t1_c_addr", 32'(log_addr(0)), 32'h05);
    checkOutput("t1_c_data", log_data(0), 32'h0000_0A0A);
    checkOutput("t1_s_addr", 32'(log_addr(1)), 32'h02);
    checkOutput("t1_s_data", log_data(1), 32'h0000_0001);
    checkOutput("t1_hold_pre", 32'(core_hold), 32'd1);
    step(100);
    pll_locked = 1'b1;
    wait_vmode("t1_vmode", 1'b1, 40);
    checkOutput("t1_hold", 32'(core_hold), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_freq", 32'(cur_freq), 32'd0);

    // Glitch shorter than the settle window must be ignored
    clear_log();
    freq_sel = 1'b1;
    step(300);
    checkOutput("t3_hold_mid", 32'(core_hold), 32'd0);
    freq_sel = 1'b0;
    step(1200);
    checkOutput("t3_nowrite", 32'(wr_addr_q.size()), 32'd0);
    checkOutput("t3_hold", 32'(core_hold), 32'd0);
    checkOutput("t3_vmode", 32'(new_vmode), 32'd1);
    checkOutput("t3_freq", 32'(cur_freq), 32'd0);

    // Switch to 50.526 MHz: latency counted from the edge that first samples freq_sel
    clear_log();
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_write_high(2000, lat);
    checkOutput("t2_latency", 32'(lat - 1), 32'd1027);
    checkOutput("t2_addr", 32'(mgmt_address), 32'h05);
    checkOutput("t2_data", mgmt_writedata, 32'h0002_0A09);
    checkOutput("t2_hold", 32'(core_hold), 32'd1);
    wait_writes("t2_writes", 2, 50);
    checkOutput("t2_s_addr", 32'(log_addr(1)), 32'h02);
    step(20);
    pll_locked = 1'b1;
    wait_vmode("t2_vmode", 1'b0, 40);
    checkOutput("t2_freq", 32'(cur_freq), 32'd1);

    // Seven stall cycles on the C write: signals must hold, exactly one completion
    clear_log();
    applyStimulus(1'b0, 1'b0, 1'b1);
    wait_write_high(1200, lat);
    checkOutput("t4_seen", 32'(mgmt_write), 32'd1);
    a_hold = mgmt_address;
    d_hold = mgmt_writedata;
    stable = 1'b1;
    repeat (6) begin
      step(1);
      if (mgmt_write !== 1'b1 || mgmt_address !== a_hold || mgmt_writedata !== d_hold) stable = 1'b0;
    end
    checkOutput("t4_nocomplete", 32'(wr_addr_q.size()), 32'd0);
    step(1);
    mgmt_waitrequest = 1'b0;
    if (mgmt_write !== 1'b1 || mgmt_address !== a_hold || mgmt_writedata !== d_hold) stable = 1'b0;
    checkOutput("t4_stable", 32'(stable), 32'd1);
    checkOutput("t4_addr", 32'(a_hold), 32'h05);
    checkOutput("t4_data", d_hold, 32'h0000_0A0A);
    wait_writes("t4_writes", 2, 50);
    step(5);
    c_writes = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] == 6'h05) c_writes++;
    checkOutput("t4_one_c", 32'(c_writes), 32'd1);
    pll_locked = 1'b1;
    wait_vmode("t4_vmode", 1'b1, 60);
    checkOutput("t4_freq", 32'(cur_freq), 32'd0);

    // Lock never arrives: three attempts, then FAULT
    clear_log();
    applyStimulus(1'b1, 1'b0, 1'b0);
    wait_error("t5_error", 3000);
    checkOutput("t5_nwrites", 32'(wr_addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t5_addr%0d", i), 32'(log_addr(i)), (i % 2 == 0) ? 32'h05 : 32'h02);
    end
    checkOutput("t5_data_last", log_data(4), 32'h0002_0A09);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_hold", 32'(core_hold), 32'd0);
    checkOutput("t5_freq", 32'(cur_freq), 32'd0);
    freq_sel = 1'b0;
    step(10);
    checkOutput("t5_error_sticky", 32'(error), 32'd1);
    clear_log();
    freq_sel = 1'b1;
    wait_writes("t5_retry_writes", 2, 1200);
    step(20);
    pll_locked = 1'b1;
    wait_vmode("t5_vmode", 1'b0, 40);
    checkOutput("t5_error_clr", 32'(error), 32'd0);
    checkOutput("t5_freq_ok", 32'(cur_freq), 32'd1);

    // Reset during WAIT_LOCK, then again in the middle of a stalled write
    clear_log();
    applyStimulus(1'b0, 1'b0, 1'b0);
    wait_writes("t6_writes", 2, 1200);
    step(20);
    checkOutput("t6_hold_pre", 32'(core_hold), 32'd1);
    RESET = 1'b1;
    #1;
    checkOutput("t6_rst_write", 32'(mgmt_write), 32'd0);
    checkOutput("t6_rst_hold", 32'(core_hold), 32'd1);
    checkOutput("t6_rst_freq", 32'(cur_freq), 32'd0);
    step(2);
    mgmt_waitrequest = 1'b1;
    RESET = 1'b0;
    wait_write_high(50, lat);
    checkOutput("t6_no_settle", 32'(lat <= 3), 32'd1);
    checkOutput("t6_addr", 32'(mgmt_address), 32'h05);
    checkOutput("t6_data", mgmt_writedata, 32'h0000_0A0A);
    RESET = 1'b1;
    #1;
    checkOutput("t6_drop_write", 32'(mgmt_write), 32'd0);
    checkOutput("t6_drop_addr", 32'(mgmt_address), 32'd0);
    step(2);
    clear_log();
    mgmt_waitrequest = 1'b0;
    RESET = 1'b0;
    wait_writes("t6_rewrites", 2, 50);
    checkOutput("t6_re_c", log_data(0), 32'h0000_0A0A);
    checkOutput("t6_re_s", 32'(log_addr(1)), 32'h02);
    step(20);
    pll_locked = 1'b1;
    wait_vmode("t6_vmode", 1'b1, 40);
    checkOutput("t6_freq", 32'(cur_freq), 32'd0);
    checkOutput("t6_hold", 32'(core_hold), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
